// File: rtl/rv_pkg.sv
// Shared types and constants for the RISC-V pipeline instruction memory.
// Holds the fill/bubble encodings, the FSM state type and the index-width helper.
package rv_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] BUBBLE_PC = 32'hFFFF_FFFC;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } imem_state_t;

  // Word-index width for a memory of the given depth (never zero).
  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x XLEN instruction storage: one synchronous write port and one
// synchronous read-first read port. Contents are not reset.
module imem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 128,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]  wdata,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [XLEN-1:0]  rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments, so a same-word
  // read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory for the IF stage: NOP boot fill, runtime
// program load, one-cycle registered fetch with flush and fault reporting.
module instr_mem_sync
  import rv_pkg::*;
#(
  parameter int              XLEN      = rv_pkg::XLEN,
  parameter int              DEPTH     = 128,
  parameter logic [XLEN-1:0] NOP       = rv_pkg::NOP_INSTR,
  parameter logic [XLEN-1:0] BUBBLE_PC = rv_pkg::BUBBLE_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_instr,
  output logic            resp_fault,
  input  logic            flush,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_addr,
  input  logic [XLEN-1:0] load_data,
  output logic            busy,
  output imem_state_t     dbg_state
);

  localparam int IDX_W = idx_w(DEPTH);

  imem_state_t      state, state_nxt;
  logic [IDX_W-1:0] cnt;

  logic             req_bubble, req_misal, req_oor, req_hit, req_flt;
  logic             load_ok, accept;
  logic             mem_we, mem_re, use_mem;
  logic [IDX_W-1:0] mem_waddr;
  logic [XLEN-1:0]  mem_wdata, mem_rdata;

  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:    if (cnt == IDX_W'(DEPTH - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Handshakes: a transfer happens on an edge where valid && ready are both
  // high. With a single output register, a request is only taken when the
  // held response is empty or is being consumed in the same cycle.
  always_comb begin
    busy      = (state == BOOT);
    req_ready = (state == RUN) && (!resp_valid || resp_ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              cnt <= '0;
    else if (state == BOOT) cnt <= cnt + 1'b1;
  end

  // Out-of-range is taken from all upper address bits, so no index wraps.
  assign req_bubble = (req_addr == BUBBLE_PC);
  assign req_misal  = (req_addr[1:0] != 2'b00);
  assign req_oor    = |req_addr[XLEN-1:IDX_W+2];
  assign req_flt    = !req_bubble && (req_misal || req_oor);
  assign req_hit    = !req_bubble && !req_misal && !req_oor;

  assign load_ok = (state == RUN) && load_en && (load_addr[1:0] == 2'b00)
                   && !(|load_addr[XLEN-1:IDX_W+2]);
  assign accept  = req_valid && req_ready;

  assign mem_we    = (state == BOOT) || load_ok;
  assign mem_waddr = (state == BOOT) ? cnt : load_addr[IDX_W+1:2];
  assign mem_wdata = (state == BOOT) ? NOP : load_data;
  assign mem_re    = accept && !flush && req_hit;

  imem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .re    (mem_re),
    .raddr (req_addr[IDX_W+1:2]),
    .rdata (mem_rdata)
  );

  // use_mem selects the array word; otherwise the response reads as NOP.
  // Flush wins over an acceptance in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      use_mem    <= 1'b0;
    end else if (flush) begin
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      use_mem    <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_fault <= req_flt;
      use_mem    <= req_hit;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign resp_instr = use_mem ? mem_rdata : NOP;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: fetch vector table through an
// expected-response queue, plus stall, flush, collision and reset sequences.
module tb_instr_mem_sync;
  import rv_pkg::*;

  localparam logic [31:0] NOPW = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_instr;
  logic        resp_fault;
  logic        flush, load_en;
  logic [31:0] load_addr, load_data;
  logic        busy;
  imem_state_t dbg_state;

  int tests = 0;
  int fails = 0;

  logic [32:0] exp_q[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  vec_t vecs[10];

  instr_mem_sync #(.DEPTH(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_fault (resp_fault),
    .flush      (flush),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: a response is consumed when resp_valid && resp_ready
  always @(negedge clk) begin
    if (reset === 1'b0 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: got %h/%b with empty queue", resp_instr, resp_fault);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("resp", {31'd0, resp_fault, resp_instr}, {31'd0, e});
      end
    end
  end

  // driver tasks
  task automatic wait_boot(input string name);
    int n = 0;
    while (busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    check({name, "_cycles"}, n, 128);
    check({name, "_ready"}, req_ready, 1);
    check({name, "_state"}, dbg_state, RUN);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    req_valid = 1'b1; req_addr = a; resp_ready = 1'b1;
    exp_q.push_back({ef, ei});
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_valid"}, resp_valid, 0);
    check({name, "_instr"}, resp_instr, NOPW);
    check({name, "_fault"}, resp_fault, 0);
    check({name, "_busy"}, busy, 1);
    check({name, "_ready"}, req_ready, 0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0000, NOPW,          1'b0};
    vecs[1] = '{32'h0000_0004, NOPW,          1'b0};
    vecs[2] = '{32'h0000_0008, 32'h0050_0093, 1'b0};
    vecs[3] = '{32'h0000_000C, NOPW,          1'b0};
    vecs[4] = '{32'h0000_0006, NOPW,          1'b1};
    vecs[5] = '{32'h0000_0200, NOPW,          1'b1};
    vecs[6] = '{32'hFFFF_FFFC, NOPW,          1'b0};
    vecs[7] = '{32'h0000_01FC, 32'hCAFE_0001, 1'b0};
    vecs[8] = '{32'h8000_0000, NOPW,          1'b1};
    vecs[9] = '{32'h0000_0202, NOPW,          1'b1};

    reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    #23;
    check_reset_outputs("reset");
    check("reset_state", dbg_state, BOOT);

    // boot with a load attempt that must be ignored
    @(posedge clk); #1;
    reset = 1'b0;
    load_en = 1'b1; load_addr = 32'h0000_000C; load_data = 32'h1234_5678;
    wait_boot("boot");
    load_en = 1'b0;

    // first fetch after boot
    fetch(32'h0, NOPW, 1'b0);
    check("first_valid", resp_valid, 1);
    tick();

    // loads: two valid, one misaligned and one out of range (ignored)
    do_load(32'h0000_0008, 32'h0050_0093);
    do_load(32'h0000_01FC, 32'hCAFE_0001);
    do_load(32'h0000_000A, 32'h1111_1111);
    do_load(32'h0000_0200, 32'h2222_2222);

    fetch(32'h8, 32'h0050_0093, 1'b0);
    check("load_latency_valid", resp_valid, 1);
    check("load_latency_instr", resp_instr, 32'h0050_0093);
    tick();

    // back-to-back table stream, one response per cycle
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'b1; req_addr = vecs[i].addr; resp_ready = 1'b1;
      exp_q.push_back({vecs[i].fault, vecs[i].instr});
      tick();
      if (i > 0) check("stream_valid", resp_valid, 1);
    end
    req_valid = 1'b0;
    tick(); tick();

    // stall: held response, new address offered but not accepted
    req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'h0050_0093});
    tick();
    req_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", resp_valid, 1);
      check("stall_instr", resp_instr, 32'h0050_0093);
      check("stall_ready", req_ready, 0);
      tick();
    end
    resp_ready = 1'b1;
    exp_q.push_back({1'b0, NOPW});
    tick();
    check("unstall_valid", resp_valid, 1);
    check("unstall_instr", resp_instr, NOPW);
    req_valid = 1'b0;
    tick(); tick();

    // flush together with an accepted request
    req_valid = 1'b1; req_addr = 32'h8; flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_valid", resp_valid, 0);
    check("flush_instr", resp_instr, NOPW);
    tick();

    // load and fetch of the same word in one cycle: read-first
    load_en = 1'b1; load_addr = 32'h10; load_data = 32'hDEAD_BEEF;
    fetch(32'h10, NOPW, 1'b0);
    load_en = 1'b0;
    fetch(32'h10, 32'hDEAD_BEEF, 1'b0);
    tick(); tick();

    // reset mid-stall in RUN
    req_valid = 1'b1; req_addr = 32'h8; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_run");
    exp_q.delete();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset mid-boot at counter 50
    for (int i = 0; i < 50; i++) tick();
    check("midboot_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_boot");
    @(posedge clk); #1;
    reset = 1'b0;
    wait_boot("reboot");

    // previously loaded words are back to NOP
    fetch(32'h8, NOPW, 1'b0);
    fetch(32'h10, NOPW, 1'b0);
    fetch(32'h1FC, NOPW, 1'b0);
    tick(); tick();

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised synchronous instruction memory for the 5-stage RISC-V pipeline; replaces the combinational word-indexed ROM.
- Adds:
  - a boot sequence that fills every word with NOP;
  - a runtime program-load write port;
  - a one-cycle registered fetch with valid/ready handshake;
  - flush support and fault reporting for bad addresses.
- Sits between the IF-stage PC register and the IF/ID pipeline register.

Parameters:
- XLEN, 32, address and instruction width.
- DEPTH, 128, number of instruction words; power of two, minimum 4.
- NOP, 32'h00000013, fill and bubble instruction (addi x0,x0,0).
- BUBBLE_PC, 32'hFFFFFFFC, PC sentinel meaning "no fetch"; returns NOP with no fault.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous, active-high.
- req_valid, input, 1, fetch request present.
- req_ready, output, 1, request accepted this cycle when high together with req_valid.
- req_addr, input, XLEN, byte address (PC).
- resp_valid, output, 1, resp_instr and resp_fault are valid.
- resp_ready, input, 1, consumer accepts the response; low means stall.
- resp_instr, output, XLEN, fetched instruction.
- resp_fault, output, 1, misaligned or out-of-range fetch.
- flush, input, 1, squash the held or in-flight response.
- load_en, input, 1, program write strobe.
- load_addr, input, XLEN, byte address for the write.
- load_data, input, XLEN, instruction word to write.
- busy, output, 1, boot fill in progress.

Behaviour:
- States: BOOT, RUN.
- Reset (asynchronous):
  - state=BOOT, fill counter=0.
  - resp_valid=0, resp_instr=NOP, resp_fault=0, busy=1, req_ready=0.
  - Memory contents are not reset asynchronously; the BOOT fill overwrites them.
- BOOT:
  - Each cycle writes NOP to mem[counter] and increments the counter.
  - When counter==DEPTH-1 is written, the next state is RUN and busy drops the following cycle.
  - Total BOOT duration is DEPTH cycles after reset deasserts.
  - req_ready=0 and load_en is ignored throughout.
  - Reset asserted mid-BOOT restarts the counter at 0.
- RUN:
  - req_ready = !resp_valid || resp_ready (single output register, no skid buffer).
  - Request accepted (req_valid && req_ready): on the next edge resp_valid=1 and the result registers are loaded. Latency is exactly 1 cycle.
  - Result selection:
    - req_addr==BUBBLE_PC: instr=NOP, fault=0.
    - req_addr[1:0]!=0: instr=NOP, fault=1.
    - (req_addr>>2) >= DEPTH: instr=NOP, fault=1.
    - otherwise: instr=mem[req_addr>>2], fault=0.
  - resp_ready=0 with resp_valid=1: resp_instr and resp_fault hold unchanged; req_ready=0.
  - Response consumed with no new request accepted: resp_valid clears next edge; resp_instr keeps its last value.
  - flush=1: next edge resp_valid=0 and resp_instr=NOP, regardless of resp_ready or any request accepted that same cycle. flush takes priority over acceptance; the accepted request is dropped.
- Program load (RUN only):
  - load_en=1 writes load_data to mem[load_addr>>2] at the edge.
  - Misaligned or out-of-range load addresses are silently ignored.
  - Write and fetch to the same word in the same cycle: the fetch returns the old word (read-first); the new word is visible from the next request.
- Index arithmetic: index = req_addr[log2(DEPTH)+1:2]. Out-of-range is detected from the full upper bits, never by wrap-around.

Decomposition:
- Shared package rv_pkg:
  - NOP_INSTR constant.
  - BUBBLE_PC constant.
  - XLEN.
  - imem_state_t enum {BOOT, RUN}.
  - clog2-based index-width helper.
- Sub-module imem_array: DEPTH x XLEN storage with one synchronous write port and one synchronous read-first read port. The controller muxes the boot-fill and load writes onto that write port.

Test Plan:
1. Reset, then release with DEPTH=128:
   - busy=1 for exactly 128 cycles, then 0.
   - req_ready rises the cycle busy falls.
   - A fetch at 0x00 returns 0x00000013, fault=0.
2. Load then fetch:
   - load 0x00500093 at 0x08, then request 0x08 with resp_ready=1.
   - One cycle later: resp_valid=1, resp_instr=0x00500093, fault=0.
   - Back-to-back requests 0x00,0x04,0x08 stream with one response per cycle.
3. Faults:
   - Request 0x06 gives NOP with fault=1.
   - Request 0x200 (index 128) gives NOP with fault=1.
   - Request 0xFFFFFFFC gives NOP with fault=0.
4. Stall:
   - Response 0x00500093 valid with resp_ready=0 for 3 cycles: output stable, req_ready=0, a new req_addr is not accepted.
   - After resp_ready=1, the next request completes 1 cycle later.
5. Flush and collision:
   - flush together with an accepted request: next cycle resp_valid=0, resp_instr=NOP.
   - load 0xDEADBEEF and fetch the same word 0x10 in one cycle: old word returned; a re-fetch returns 0xDEADBEEF.
6. Reset mid-operation:
   - Assert reset asynchronously mid-BOOT (counter=50) and mid-stall in RUN.
   - Outputs go to reset values immediately, without waiting for a clock edge.
   - Full 128-cycle BOOT repeats; previously loaded words read as NOP afterwards.
